collision_scanner: RTL and testbench

- Per-frame sequencer that sits directly upstream of the rectangle-overlap checker.
- On each frame start it snapshots the player hitbox and walks the obstacle table one entry at a time. It presents the player and obstacle hitboxes to the overlap checker and samples its Collided result.
- Reports whether any valid obstacle was hit, the lowest-index hit and the hit count. The game-state FSM consumes these results.

---
 rtl/collision_scanner.sv | 119 +++++++++++
 tb/tb_collision_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// Per-frame obstacle scanner: snapshots the player hitbox, walks the obstacle table
// through the external overlap checker and reports first hit index and hit count.
module collision_scanner #(
    parameter int NUM_OBJ = 16,
    parameter int IDX_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [9:0]       PlayerX,
    input  logic [9:0]       PlayerY,
    input  logic [9:0]       PlayerW,
    input  logic [9:0]       PlayerH,
    output logic [IDX_W-1:0] ObjIdx,
    input  logic [9:0]       ObjX,
    input  logic [9:0]       ObjY,
    input  logic [9:0]       ObjW,
    input  logic [9:0]       ObjH,
    input  logic             ObjValid,
    output logic [9:0]       X1,
    output logic [9:0]       Y1,
    output logic [9:0]       Width1,
    output logic [9:0]       Height1,
    output logic [9:0]       X2,
    output logic [9:0]       Y2,
    output logic [9:0]       Width2,
    output logic [9:0]       Height2,
    input  logic             Collided,
    output logic             Busy,
    output logic             Done,
    output logic             Hit,
    output logic [IDX_W-1:0] HitIdx,
    output logic [IDX_W:0]   HitCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    state_t state;
    logic   entry_hit;

    // Obstacle data goes straight to the checker; only the player side is registered.
    assign X2      = ObjX;
    assign Y2      = ObjY;
    assign Width2  = ObjW;
    assign Height2 = ObjH;

    assign entry_hit = Collided & ObjValid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            ObjIdx   <= '0;
            X1       <= '0;
            Y1       <= '0;
            Width1   <= '0;
            Height1  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hit      <= 1'b0;
            HitIdx   <= '0;
            HitCount <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        X1       <= PlayerX;
                        Y1       <= PlayerY;
                        Width1   <= PlayerW;
                        Height1  <= PlayerH;
                        Hit      <= 1'b0;
                        HitIdx   <= '0;
                        HitCount <= '0;
                        ObjIdx   <= '0;
                        Busy     <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // Only the first hit records its index, so HitIdx is the lowest one.
                    if (entry_hit && !Hit) begin
                        Hit    <= 1'b1;
                        HitIdx <= ObjIdx;
                    end
                    if (entry_hit) begin
                        HitCount <= HitCount + CNT_ONE;
                    end
                    if (ObjIdx == LAST_IDX) begin
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ObjIdx <= ObjIdx + IDX_ONE;
                        state  <= S_ADDR;
                    end
                end
                S_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner with a synchronous obstacle table model
// and a behavioural rectangle-overlap checker.
module tb_collision_scanner;

    localparam int NUM_OBJ = 16;
    localparam int IDX_W   = 4;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic [9:0]       PlayerX = 10'd100;
    logic [9:0]       PlayerY = 10'd100;
    logic [9:0]       PlayerW = 10'd16;
    logic [9:0]       PlayerH = 10'd16;
    logic [IDX_W-1:0] ObjIdx;
    logic [9:0]       ObjX, ObjY, ObjW, ObjH;
    logic             ObjValid;
    logic [9:0]       X1, Y1, Width1, Height1;
    logic [9:0]       X2, Y2, Width2, Height2;
    logic             Collided;
    logic             Busy, Done, Hit;
    logic [IDX_W-1:0] HitIdx;
    logic [IDX_W:0]   HitCount;

    logic [9:0] tbl_x [NUM_OBJ];
    logic [9:0] tbl_y [NUM_OBJ];
    logic [9:0] tbl_w [NUM_OBJ];
    logic [9:0] tbl_h [NUM_OBJ];
    logic       tbl_v [NUM_OBJ];

    int compared = 0;
    int mismatched = 0;

    collision_scanner #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerW(PlayerW), .PlayerH(PlayerH),
        .ObjIdx(ObjIdx), .ObjX(ObjX), .ObjY(ObjY), .ObjW(ObjW), .ObjH(ObjH),
        .ObjValid(ObjValid),
        .X1(X1), .Y1(Y1), .Width1(Width1), .Height1(Height1),
        .X2(X2), .Y2(Y2), .Width2(Width2), .Height2(Height2),
        .Collided(Collided), .Busy(Busy), .Done(Done), .Hit(Hit),
        .HitIdx(HitIdx), .HitCount(HitCount)
    );

    always #5 Clk = ~Clk;

    // Synchronous obstacle table: data follows the address by one clock.
    always @(posedge Clk) begin
        ObjX     <= tbl_x[ObjIdx];
        ObjY     <= tbl_y[ObjIdx];
        ObjW     <= tbl_w[ObjIdx];
        ObjH     <= tbl_h[ObjIdx];
        ObjValid <= tbl_v[ObjIdx];
    end

    // Strict overlap: rectangles that merely share an edge do not collide.
    always_comb begin
        Collided = (int'(X1) < int'(X2) + int'(Width2)) && (int'(X2) < int'(X1) + int'(Width1)) &&
                   (int'(Y1) < int'(Y2) + int'(Height2)) && (int'(Y2) < int'(Y1) + int'(Height1));
    end

    typedef struct {
        logic [15:0] ovl;
        logic [15:0] touch;
        logic [15:0] valid;
        int          exp_hit;
        int          exp_idx;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic load_table(input logic [15:0] ovl, input logic [15:0] touch,
                              input logic [15:0] valid);
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (ovl[i]) begin
                tbl_x[i] = 10'd108; tbl_y[i] = 10'd104;
            end else if (touch[i]) begin
                tbl_x[i] = 10'd116; tbl_y[i] = 10'd100;
            end else begin
                tbl_x[i] = 10'd300; tbl_y[i] = 10'd300;
            end
            tbl_w[i] = 10'd16;
            tbl_h[i] = 10'd16;
            tbl_v[i] = valid[i];
        end
    endtask

    // Pulses Start for one cycle and returns the cycle number of Done (-1 on timeout).
    task automatic applyStimulus(output int latency);
        int n;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        n = 0;
        while (!Done && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        latency = Done ? n + 1 : -1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int done_cnt;
        int done_cyc;
        int busy_drop;

        vecs[0] = '{16'h0020, 16'h0000, 16'h0020, 1, 5, 1};
        vecs[1] = '{16'h808C, 16'h0000, 16'hFFFB, 1, 3, 3};
        vecs[2] = '{16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1, 0, 16};
        vecs[4] = '{16'h8000, 16'h0000, 16'h8000, 1, 15, 1};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[6] = '{16'h0001, 16'h0000, 16'hFFFF, 1, 0, 1};

        load_table(16'h0, 16'h0, 16'h0);

        // Reset held for three cycles, then idle without Start.
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_done", Done, 0);
        checkOutput("reset_hit", Hit, 0);
        checkOutput("reset_hitidx", HitIdx, 0);
        checkOutput("reset_hitcount", HitCount, 0);
        checkOutput("reset_objidx", ObjIdx, 0);
        checkOutput("reset_x1", X1, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk);
            #1;
            if (Done) done_cnt++;
        end
        checkOutput("idle_done_count", done_cnt, 0);
        checkOutput("idle_busy", Busy, 0);

        // Table-driven scans.
        for (int v = 0; v < 7; v++) begin
            load_table(vecs[v].ovl, vecs[v].touch, vecs[v].valid);
            applyStimulus(lat);
            checkOutput($sformatf("v%0d_latency", v), lat, 2 * NUM_OBJ + 1);
            checkOutput($sformatf("v%0d_busy_at_done", v), Busy, 1);
            checkOutput($sformatf("v%0d_hit", v), Hit, vecs[v].exp_hit);
            checkOutput($sformatf("v%0d_hitidx", v), HitIdx, vecs[v].exp_idx);
            checkOutput($sformatf("v%0d_hitcount", v), HitCount, vecs[v].exp_cnt);
            checkOutput($sformatf("v%0d_x1", v), X1, 100);
            checkOutput($sformatf("v%0d_objidx", v), ObjIdx, NUM_OBJ - 1);
            @(posedge Clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulse", v), Done, 0);
            checkOutput($sformatf("v%0d_busy_after", v), Busy, 0);
            checkOutput($sformatf("v%0d_hit_held", v), Hit, vecs[v].exp_hit);
        end

        // Snapshot freeze and Start while busy (including coincident with Done).
        load_table(16'h0020, 16'h0000, 16'h0020);
        PlayerX = 10'd100;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        done_cnt = 0;
        done_cyc = -1;
        busy_drop = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge Clk);
            Start = (k == 12 || k == 33);
            if (k == 10) PlayerX = 10'd0;
            @(posedge Clk);
            #1;
            if (Done) begin
                done_cnt++;
                done_cyc = k + 1;
            end
            if (!Busy && busy_drop < 0) busy_drop = k + 1;
        end
        Start = 1'b0;
        checkOutput("snap_done_count", done_cnt, 1);
        checkOutput("snap_done_cycle", done_cyc, 33);
        checkOutput("snap_busy_drop", busy_drop, 34);
        checkOutput("snap_hit", Hit, 1);
        checkOutput("snap_hitidx", HitIdx, 5);
        checkOutput("snap_hitcount", HitCount, 1);
        checkOutput("snap_x1", X1, 100);
        PlayerX = 10'd100;

        // Mid-scan asynchronous reset after a hit at entry 1.
        load_table(16'h0002, 16'h0000, 16'h0002);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge Clk);
            #1;
        end
        checkOutput("mid_hit_before", Hit, 1);
        checkOutput("mid_busy_before", Busy, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_busy_cleared", Busy, 0);
        checkOutput("mid_hit_cleared", Hit, 0);
        checkOutput("mid_hitidx_cleared", HitIdx, 0);
        checkOutput("mid_hitcount_cleared", HitCount, 0);
        checkOutput("mid_objidx_cleared", ObjIdx, 0);
        checkOutput("mid_x1_cleared", X1, 0);
        done_cnt = 0;
        repeat (2) begin
            @(posedge Clk);
            #1;
            if (Done) done_cnt++;
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk);
            #1;
            if (Done) done_cnt++;
        end
        checkOutput("mid_no_done", done_cnt, 0);
        checkOutput("mid_idle_busy", Busy, 0);
        applyStimulus(lat);
        checkOutput("mid_rescan_latency", lat, 2 * NUM_OBJ + 1);
        checkOutput("mid_rescan_hit", Hit, 1);
        checkOutput("mid_rescan_hitidx", HitIdx, 1);
        checkOutput("mid_rescan_hitcount", HitCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
